// File: rtl/mux_rr_pipe.sv
// N-channel registered multiplexer with valid/ready on every port.
// The channel is picked by an external select or round-robin, and the data path is a chained c1 AND-OR tree.

module mux_rr_pipe_c1 (
  input  logic i_a,
  input  logic i_s,
  input  logic i_c,
  output logic o_y
);
  assign o_y = (i_a & i_s) | i_c;
endmodule

module mux_rr_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);
  // Handshake: a word moves on channel i in any cycle where in_valid[i] and
  // in_ready[i] are both high at the rising edge; out_data/out_chan are
  // consumed in any cycle where out_valid and out_ready are both high.

  logic [N-1:0]     w_grant;
  logic [N-1:0]     w_in_ready;
  logic [SELW-1:0]  w_gidx;
  logic             w_load_en;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux;
  int               w_best_d;
  int               w_d;

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;
  logic             r_out_valid;
  logic [SELW-1:0]  r_rr_ptr;

  // Round-robin uses each channel's circular distance from rr_ptr+1; the nearest valid channel wins.
  always_comb begin
    w_grant  = '0;
    w_gidx   = '0;
    w_best_d = N;
    w_d      = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i)) begin
          w_grant[i] = in_valid[i];
          w_gidx     = SELW'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        w_d = (i + 2 * N - 1 - int'(r_rr_ptr)) % N;
        if (in_valid[i] && (w_d < w_best_d)) begin
          w_best_d = w_d;
          w_gidx   = SELW'(i);
        end
      end
      for (int i = 0; i < N; i++) begin
        w_grant[i] = (w_best_d < N) && (w_gidx == SELW'(i));
      end
    end
  end

  assign w_load_en  = ~r_out_valid | out_ready;
  assign w_in_ready = rst ? '0 : (w_grant & {N{w_load_en}});
  assign w_xfer     = |(w_in_ready & in_valid);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [N:0] w_chain;
    assign w_chain[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g_ch
      mux_rr_pipe_c1 u_c1 (
        .i_a (in_data[i*WIDTH+b]),
        .i_s (w_grant[i]),
        .i_c (w_chain[i]),
        .o_y (w_chain[i+1])
      );
    end
    assign w_mux[b] = w_chain[N];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= SELW'(N - 1);
    end else if (w_xfer) begin
      r_out_data  <= w_mux;
      r_out_chan  <= w_gidx;
      r_out_valid <= 1'b1;
      if (mode) r_rr_ptr <= w_gidx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed bench for mux_rr_pipe: a 4-channel instance with a word scoreboard,
// plus a 5-channel instance for out-of-range select values.
`timescale 1ns/1ps

module tb_mux_rr_pipe;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic        mode5;
  logic [2:0]  sel5;
  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_chan5;
  logic        out_valid5;
  logic        out_ready5;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];
  logic [9:0] m_exp;
  logic [9:0] m_got;
  logic [7:0] cur[4];
  logic [7:0] v_d;
  logic [7:0] v_e;

  mux_rr_pipe #(.WIDTH(W), .N(4)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_rr_pipe #(.WIDTH(W), .N(5)) u_dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .in_data(in_data5),
    .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
    .out_chan(out_chan5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [7:0] v);
    in_data[c*8 +: 8] = v;
    cur[c] = v;
  endtask

  // A word leaves the DUT at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      m_got = {out_chan, out_data};
      m_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'bx;
      vectors++;
      assert (m_got === m_exp) else begin
        miscompares++;
        $error("FAIL sb_word observed=%0h expected=%0h", m_got, m_exp);
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    mode5 = 1'b0; sel5 = 3'd0; in_data5 = '0; in_valid5 = '0; out_ready5 = 1'b0;
    for (int i = 0; i < 4; i++) cur[i] = 8'h00;

    // Reset
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    in_valid = 4'b1111;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 4'b0000;
    rst = 1'b0;
    tick();

    // External select, single word
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    set_ch(2, 8'hA5);
    #1;
    chk("ext_in_ready", 32'(in_ready), 32'h4);
    exp_q.push_back({2'd2, 8'hA5});
    tick();
    in_valid = 4'b0000;
    chk("ext_out_valid", 32'(out_valid), 32'd1);
    chk("ext_out_data", 32'(out_data), 32'hA5);
    chk("ext_out_chan", 32'(out_chan), 32'd2);
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_hold_data", 32'(out_data), 32'hA5);

    // Round-robin, all channels valid: 0,1,2,3,0 at one word per cycle
    mode = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(i, 8'($urandom_range(0, 255)));
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      exp_q.push_back({2'(k % 4), cur[k % 4]});
      tick();
      chk("rr_out_chan", 32'(out_chan), 32'(k % 4));
      chk("rr_out_valid", 32'(out_valid), 32'd1);
      set_ch(k % 4, 8'($urandom_range(0, 255)));
    end
    in_valid = 4'b0000;
    tick();
    chk("rr_drain", 32'(out_valid), 32'd0);

    // Move rr_ptr to 3, then skip idle channels: 1,3,1
    in_valid = 4'b1000;
    exp_q.push_back({2'd3, cur[3]});
    tick();
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("skip_in_ready", 32'(in_ready), (k == 1) ? 32'h8 : 32'h2);
      exp_q.push_back({(k == 1) ? 2'd3 : 2'd1, (k == 1) ? cur[3] : cur[1]});
      tick();
      chk("skip_out_chan", 32'(out_chan), (k == 1) ? 32'd3 : 32'd1);
      set_ch((k == 1) ? 3 : 1, 8'($urandom_range(0, 255)));
    end
    in_valid = 4'b0000;
    tick();

    // Back-pressure: the held word is stable and in_ready stays low
    out_ready = 1'b0;
    v_d = 8'($urandom_range(0, 255));
    set_ch(0, v_d);
    in_valid = 4'b0001;
    #1;
    chk("bp_first_ready", 32'(in_ready), 32'h1);
    exp_q.push_back({2'd0, v_d});
    tick();
    v_e = ~v_d;
    set_ch(0, v_e);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_hold_data", 32'(out_data), 32'(v_d));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    exp_q.push_back({2'd0, v_e});
    tick();
    chk("bp_next_data", 32'(out_data), 32'(v_e));
    in_valid = 4'b0000;
    tick();

    // Reset while a word is held: it is discarded and rr_ptr returns to 3
    out_ready = 1'b0;
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b0000;
    chk("mid_loaded", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk("mid_rr_restart", 32'(in_ready), 32'h1);

    // Mode/sel changes act on the same cycle's grant
    mode = 1'b0; sel = 2'd1;
    #1;
    chk("sel1_grant", 32'(in_ready), 32'h2);
    sel = 2'd3;
    #1;
    chk("sel3_grant", 32'(in_ready), 32'h8);
    in_valid = 4'b0000;
    out_ready = 1'b1;
    tick();

    // Out-of-range select on the 5-channel instance
    mode5 = 1'b0; sel5 = 3'd4; in_valid5 = 5'b10000; out_ready5 = 1'b1;
    in_data5[4*8 +: 8] = 8'hC3;
    tick();
    chk("n5_out_chan", 32'(out_chan5), 32'd4);
    chk("n5_out_data", 32'(out_data5), 32'hC3);
    sel5 = 3'd5; in_valid5 = 5'b11111;
    #1;
    chk("n5_sel5_ready", 32'(in_ready5), 32'd0);
    tick();
    chk("n5_sel5_drain", 32'(out_valid5), 32'd0);
    sel5 = 3'd7;
    #1;
    chk("n5_sel7_ready", 32'(in_ready5), 32'd0);
    in_valid5 = 5'b00000;
    tick();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
